// File: rtl/clock_pkg.sv
// Shared types and default constants for the clock/timer time-field counters.
package clock_pkg;

   typedef enum logic [1:0] {
      REP_IDLE,
      REP_HOLD,
      REP_REPEAT
   } rep_state_t;

   localparam int SEC_MOD         = 60;
   localparam int HOUR_MOD        = 24;
   localparam int REP_DELAY_DFLT  = 50;
   localparam int REP_PERIOD_DFLT = 10;

endpackage

// File: rtl/repeat_gen.sv
// Hold-to-repeat step generator for the add/minus edit buttons.
module repeat_gen
   import clock_pkg::*;
#(
   parameter int REP_DELAY  = REP_DELAY_DFLT,
   parameter int REP_PERIOD = REP_PERIOD_DFLT,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic add,
   input  logic minus,
   input  logic clr,
   output logic step,
   output logic step_dir,
   output logic active
);

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

   logic             btn;
   logic             dir;
   logic             btn_prev;
   logic             dir_prev;
   logic             dir_flip;
   rep_state_t       state;
   rep_state_t       state_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_nxt;

   // Both buttons together cancel out and behave as no press at all.
   assign btn      = add ^ minus;
   assign dir      = add;
   assign dir_flip = dir ^ dir_prev;
   assign step_dir = dir;
   assign active   = (state != REP_IDLE);

   // btn_prev resets high so a button held through reset is not a new press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= REP_IDLE;
         timer    <= '0;
         btn_prev <= 1'b1;
         dir_prev <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         btn_prev <= btn;
         dir_prev <= dir;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      step      = 1'b0;
      if (clr) begin
         state_nxt = REP_IDLE;
         timer_nxt = '0;
      end else begin
         case (state)
            REP_IDLE: begin
               if (btn && !btn_prev) begin
                  step      = 1'b1;
                  timer_nxt = '0;
                  state_nxt = REP_HOLD;
               end
            end
            REP_HOLD: begin
               if (!btn) begin
                  state_nxt = REP_IDLE;
                  timer_nxt = '0;
               end else if (dir_flip) begin
                  step      = 1'b1;
                  timer_nxt = '0;
               end else if (timer == DELAY_LAST) begin
                  step      = 1'b1;
                  timer_nxt = '0;
                  state_nxt = REP_REPEAT;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            REP_REPEAT: begin
               // A direction flip restarts the initial hold delay.
               if (!btn) begin
                  state_nxt = REP_IDLE;
                  timer_nxt = '0;
               end else if (dir_flip) begin
                  step      = 1'b1;
                  timer_nxt = '0;
                  state_nxt = REP_HOLD;
               end else if (timer == PERIOD_LAST) begin
                  step      = 1'b1;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            default: begin
               state_nxt = REP_IDLE;
               timer_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down time-field counter with tick counting, button editing,
// parallel load and registered carry/borrow for cascading fields.
module mod_updown_counter
   import clock_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MOD        = SEC_MOD,
   parameter int REP_DELAY  = REP_DELAY_DFLT,
   parameter int REP_PERIOD = REP_PERIOD_DFLT,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             run,
   input  logic             count_down,
   input  logic             add,
   input  logic             minus,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             carry,
   output logic             borrow,
   output logic             editing
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

   logic             step;
   logic             step_dir;
   logic             active;
   logic             tick_ok;
   logic [WIDTH-1:0] value_nxt;
   logic             carry_nxt;
   logic             borrow_nxt;

   // Compare against MOD-1 before adding so MOD == 2**WIDTH never overflows.
   function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
      return (v == MAX_VAL) ? '0 : v + 1'b1;
   endfunction

   function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
      return (v == '0) ? MAX_VAL : v - 1'b1;
   endfunction

   repeat_gen #(
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD),
      .CNT_W      (CNT_W)
   ) u_repeat (
      .clk      (clk),
      .rst_n    (rst_n),
      .add      (add),
      .minus    (minus),
      .clr      (load),
      .step     (step),
      .step_dir (step_dir),
      .active   (active)
   );

   assign editing = active;
   assign tick_ok = tick & run & ~active & ~load;

   // Priority: load, then manual step, then tick; only ticks ripple out.
   always_comb begin
      value_nxt  = value;
      carry_nxt  = 1'b0;
      borrow_nxt = 1'b0;
      if (load) begin
         if (load_val <= MAX_VAL) begin
            value_nxt = load_val;
         end
      end else if (step) begin
         value_nxt = step_dir ? wrap_inc(value) : wrap_dec(value);
      end else if (tick_ok) begin
         if (!count_down) begin
            carry_nxt = (value == MAX_VAL);
            value_nxt = wrap_inc(value);
         end else begin
            borrow_nxt = (value == '0);
            value_nxt  = wrap_dec(value);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value  <= '0;
         carry  <= 1'b0;
         borrow <= 1'b0;
      end else begin
         value  <= value_nxt;
         carry  <= carry_nxt;
         borrow <= borrow_nxt;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed bench for mod_updown_counter against a behavioural model.
module tb_mod_updown_counter;

   typedef struct packed {
      int v;
      int age;
      bit c;
      bit b;
      bit pressed;
      bit last_btn;
      bit pdir;
   } mst_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_tick = 0, a_run = 0, a_cd = 0, a_add = 0, a_minus = 0, a_load = 0;
   logic [7:0] a_lv = '0;
   logic [7:0] a_value;
   logic       a_carry, a_borrow, a_editing;

   logic       b_tick = 0, b_run = 0, b_cd = 0, b_add = 0, b_minus = 0, b_load = 0;
   logic [4:0] b_lv = '0;
   logic [4:0] b_value;
   logic       b_carry, b_borrow, b_editing;

   mst_t ma, mb;
   int   total = 0;
   int   bad = 0;
   int   nt;

   mod_updown_counter #(.WIDTH(8), .MOD(60), .REP_DELAY(50), .REP_PERIOD(10), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .tick(a_tick), .run(a_run), .count_down(a_cd),
      .add(a_add), .minus(a_minus), .load(a_load), .load_val(a_lv),
      .value(a_value), .carry(a_carry), .borrow(a_borrow), .editing(a_editing));

   mod_updown_counter #(.WIDTH(5), .MOD(24), .REP_DELAY(3), .REP_PERIOD(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .tick(b_tick), .run(b_run), .count_down(b_cd),
      .add(b_add), .minus(b_minus), .load(b_load), .load_val(b_lv),
      .value(b_value), .carry(b_carry), .borrow(b_borrow), .editing(b_editing));

   // Press = button seen low then high; steps at hold age 0, d, d+p, d+2p, ...
   function automatic mst_t mstep(mst_t s, int modv, int d, int p, bit rn, bit tk,
                                  bit en, bit cd, bit ad, bit mi, bit ld, int lv);
      mst_t n;
      bit   btn, dir, stp, was_ed;
      n = s;
      if (!rn) begin
         n = '0;
         n.last_btn = 1'b1;
         return n;
      end
      btn = ad ^ mi;
      dir = ad;
      stp = 1'b0;
      was_ed = s.pressed;
      n.c = 1'b0;
      n.b = 1'b0;
      if (ld) n.pressed = 1'b0;
      else if (!btn) n.pressed = 1'b0;
      else if (s.pressed && dir != s.pdir) begin
         stp = 1'b1; n.age = 0; n.pdir = dir;
      end else if (s.pressed) begin
         n.age = s.age + 1;
         if (n.age == d || (n.age > d && (n.age - d) % p == 0)) stp = 1'b1;
      end else if (!s.last_btn) begin
         n.pressed = 1'b1; n.age = 0; n.pdir = dir; stp = 1'b1;
      end
      n.last_btn = btn;
      if (ld) begin
         if (lv < modv) n.v = lv;
      end else if (stp) begin
         n.v = dir ? (s.v + 1) % modv : (s.v + modv - 1) % modv;
      end else if (tk && en && !was_ed) begin
         if (!cd) begin
            n.c = (s.v == modv - 1);
            n.v = (s.v + 1) % modv;
         end else begin
            n.b = (s.v == 0);
            n.v = (s.v + modv - 1) % modv;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma <= mstep(ma, 60, 50, 10, rst_n, a_tick, a_run, a_cd, a_add, a_minus, a_load, int'(a_lv));
      mb <= mstep(mb, 24, 3, 2, rst_n, b_tick, b_run, b_cd, b_add, b_minus, b_load, int'(b_lv));
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      chk("a_value",   int'(a_value),   ma.v);
      chk("a_carry",   int'(a_carry),   int'(ma.c));
      chk("a_borrow",  int'(a_borrow),  int'(ma.b));
      chk("a_editing", int'(a_editing), int'(ma.pressed));
      chk("b_value",   int'(b_value),   mb.v);
      chk("b_carry",   int'(b_carry),   int'(mb.c));
      chk("b_borrow",  int'(b_borrow),  int'(mb.b));
      chk("b_editing", int'(b_editing), int'(mb.pressed));
   endtask

   initial begin
      cyc();
      cyc();
      chk("lit_reset_value", int'(a_value), 0);
      chk("lit_reset_edit", int'(a_editing), 0);
      rst_n = 1'b1;
      cyc();

      // 60 up-ticks: full revolution with carry on the wrap
      a_run = 1; a_cd = 0; a_tick = 1;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (i == 59) chk("lit_up59", int'(a_value), 59);
      end
      chk("lit_wrap_value", int'(a_value), 0);
      chk("lit_wrap_carry", int'(a_carry), 1);
      a_tick = 0;
      cyc();
      chk("lit_carry_drop", int'(a_carry), 0);

      // load 0 then a down-tick borrows; out-of-range load is ignored
      a_lv = 8'd0; a_load = 1; cyc(); a_load = 0;
      a_cd = 1; a_tick = 1; cyc(); a_tick = 0;
      chk("lit_borrow_value", int'(a_value), 59);
      chk("lit_borrow", int'(a_borrow), 1);
      cyc();
      chk("lit_borrow_drop", int'(a_borrow), 0);
      a_lv = 8'd75; a_load = 1; cyc(); a_load = 0;
      chk("lit_load_oor", int'(a_value), 59);

      // hold add from 58 for 75 cycles
      a_cd = 0; a_lv = 8'd58; a_load = 1; cyc(); a_load = 0;
      a_add = 1;
      for (int i = 1; i <= 75; i++) begin
         cyc();
         if (i == 1)  chk("lit_hold_s1", int'(a_value), 59);
         if (i == 51) chk("lit_hold_s51", int'(a_value), 0);
         if (i == 61) chk("lit_hold_s61", int'(a_value), 1);
         if (i == 71) chk("lit_hold_s71", int'(a_value), 2);
         if (i == 40) chk("lit_hold_edit", int'(a_editing), 1);
      end
      a_add = 0;
      cyc();
      chk("lit_release_edit", int'(a_editing), 0);
      chk("lit_release_value", int'(a_value), 2);

      // both buttons together: no edit, ticks still count
      a_add = 1; a_minus = 1; nt = 0;
      for (int i = 0; i < 100; i++) begin
         a_tick = 1'($urandom_range(0, 1));
         if (a_tick) nt++;
         cyc();
      end
      a_tick = 0;
      chk("lit_both_edit", int'(a_editing), 0);
      chk("lit_both_value", int'(a_value), (2 + nt) % 60);
      a_add = 0; a_minus = 0;
      cyc();

      // tick, load and add press in the same cycle
      a_tick = 1; a_load = 1; a_lv = 8'd30; a_add = 1;
      cyc();
      a_tick = 0; a_load = 0;
      chk("lit_coll_value", int'(a_value), 30);
      chk("lit_coll_carry", int'(a_carry), 0);
      chk("lit_coll_edit", int'(a_editing), 0);
      repeat (3) cyc();
      chk("lit_coll_nostep", int'(a_value), 30);
      a_add = 0; cyc();
      a_add = 1; cyc();
      chk("lit_coll_next", int'(a_value), 31);
      a_add = 0; cyc();

      // reset while repeating with add held through release of reset
      a_add = 1;
      repeat (60) cyc();
      rst_n = 0;
      cyc(); cyc();
      chk("lit_rst_value", int'(a_value), 0);
      rst_n = 1;
      repeat (60) cyc();
      chk("lit_rst_held", int'(a_value), 0);
      chk("lit_rst_edit", int'(a_editing), 0);
      a_add = 0; cyc();
      a_add = 1; cyc();
      chk("lit_rst_repress", int'(a_value), 1);
      a_add = 0; cyc();

      // hours instance wraps 23 -> 0 with carry
      b_lv = 5'd22; b_load = 1; cyc(); b_load = 0;
      b_run = 1; b_tick = 1;
      cyc();
      chk("lit_b_23", int'(b_value), 23);
      cyc();
      chk("lit_b_wrap", int'(b_value), 0);
      chk("lit_b_carry", int'(b_carry), 1);
      b_tick = 0;
      cyc();

      // random traffic on both instances
      for (int i = 0; i < 4000; i++) begin
         a_tick  = 1'($urandom_range(0, 1));
         a_run   = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) a_cd = ~a_cd;
         if ($urandom_range(0, 79) == 0) {a_add, a_minus} = 2'($urandom_range(0, 3));
         a_load  = ($urandom_range(0, 39) == 0);
         a_lv    = 8'($urandom_range(0, 255));
         b_tick  = 1'($urandom_range(0, 1));
         b_run   = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 29) == 0) b_cd = ~b_cd;
         if ($urandom_range(0, 7) == 0) {b_add, b_minus} = 2'($urandom_range(0, 3));
         b_load  = ($urandom_range(0, 39) == 0);
         b_lv    = 5'($urandom_range(0, 31));
         rst_n   = ($urandom_range(0, 999) != 0);
         cyc();
      end
      rst_n = 1;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
